// File: rtl/gb_apu_pkg.sv
// Shared APU types and frame-sequencer step tables.
// Bit n of each mask selects the strobe issued when step n executes.
package gb_apu_pkg;

   localparam int unsigned FS_STEPS = 8;

   typedef logic [2:0] fs_step_t;

   localparam logic [FS_STEPS-1:0] FS_LEN_MASK   = 8'b0101_0101;
   localparam logic [FS_STEPS-1:0] FS_SWEEP_MASK = 8'b0100_0100;
   localparam logic [FS_STEPS-1:0] FS_ENV_MASK   = 8'b1000_0000;

   typedef struct packed {
      logic length;
      logic sweep;
      logic env;
   } fs_strobe_t;

   function automatic fs_strobe_t fs_decode(input fs_step_t s);
      fs_strobe_t r;
      r.length = FS_LEN_MASK[s];
      r.sweep  = FS_SWEEP_MASK[s];
      r.env    = FS_ENV_MASK[s];
      return r;
   endfunction

endpackage

// File: rtl/gb_frame_sequencer_if.sv
// Frame-sequencer control inputs and per-channel tick strobes.
// The master modport is the sequencer; the slave modport is the consuming APU logic.
interface gb_frame_sequencer_if;
   import gb_apu_pkg::*;

   logic     apu_enable;
   logic     div_bit;
   logic     frame_tick;
   fs_step_t step;
   logic     clk_length_ctr;
   logic     clk_sweep;
   logic     clk_vol_env;

   modport master (
      input  apu_enable, div_bit,
      output frame_tick, step, clk_length_ctr, clk_sweep, clk_vol_env
   );

   modport slave (
      output apu_enable, div_bit,
      input  frame_tick, step, clk_length_ctr, clk_sweep, clk_vol_env
   );
endinterface

// File: rtl/gb_fs_prescaler.sv
// Frame-event prescaler: counts 0..PRESCALE-1 while enabled, flags ev on the last count.
// Disable clears the count, so the first ev after enabling lands on the PRESCALE-th cycle.
module gb_fs_prescaler #(
   parameter int unsigned PRESCALE = 8192
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic ev
);
   localparam int unsigned   W    = $clog2(PRESCALE + 1);
   localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

   logic [W-1:0] count;

   assign ev = enable && (count == LAST);

   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         count <= '0;
      end else if (ev) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end
endmodule

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: turns the 512 Hz frame event into length/sweep/envelope strobes.
// Define GB_FS_EXT_DIV_EN to take the frame event from falling edges of DIV bit 4.
module gb_frame_sequencer
   import gb_apu_pkg::*;
#(
   parameter int unsigned PRESCALE = 8192
) (
   input  logic                  clk,
   input  logic                  reset,
   gb_frame_sequencer_if.master  fs
);
   logic       ev;
   fs_step_t   step_q;
   fs_step_t   step_d;
   logic       tick_d;
   fs_strobe_t strobe_d;

`ifdef GB_FS_EXT_DIV_EN
   localparam int unsigned unused_prescale = PRESCALE;
   logic div_prev;

   // div_prev follows div_bit even while disabled so re-enable sees no stale edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_prev <= 1'b0;
      end else begin
         div_prev <= fs.div_bit;
      end
   end

   assign ev = fs.apu_enable & div_prev & ~fs.div_bit;
`else
   logic unused_div;
   assign unused_div = fs.div_bit;

   gb_fs_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (fs.apu_enable),
      .ev     (ev)
   );
`endif

   // Strobes reflect the step being executed, i.e. the value before the increment.
   always_comb begin
      step_d   = step_q;
      tick_d   = 1'b0;
      strobe_d = '0;
      if (ev) begin
         step_d   = step_q + 3'd1;
         tick_d   = 1'b1;
         strobe_d = fs_decode(step_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || !fs.apu_enable) begin
         step_q            <= '0;
         fs.frame_tick     <= 1'b0;
         fs.clk_length_ctr <= 1'b0;
         fs.clk_sweep      <= 1'b0;
         fs.clk_vol_env    <= 1'b0;
      end else begin
         step_q            <= step_d;
         fs.frame_tick     <= tick_d;
         fs.clk_length_ctr <= strobe_d.length;
         fs.clk_sweep      <= strobe_d.sweep;
         fs.clk_vol_env    <= strobe_d.env;
      end
   end

   assign fs.step = step_q;
endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Bench for gb_frame_sequencer: PRESCALE=4 and PRESCALE=1 instances against a step-count model.
// Builds with or without GB_FS_EXT_DIV_EN; count-specific checks follow the build.
module tb_gb_frame_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic apu_enable;
   logic div_bit;

   always #5 clk = ~clk;

   gb_frame_sequencer_if if4 ();
   gb_frame_sequencer_if if1 ();

   assign if4.apu_enable = apu_enable;
   assign if4.div_bit    = div_bit;
   assign if1.apu_enable = apu_enable;
   assign if1.div_bit    = div_bit;

   gb_frame_sequencer #(.PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .fs(if4));
   gb_frame_sequencer #(.PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .fs(if1));

   int errors = 0;
   int checks = 0;

   // Reference model: enabled-cycle count since clear, frames executed, DIV history.
   int         P [2] = '{4, 1};
   int         m_cnt  [2];
   int         m_step [2];
   logic [6:0] m_out  [2];
   logic       m_divprev;
   int         n_tick [2];
   int         n_len  [2];
   int         n_sweep[2];
   int         n_env  [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic next_ev(input int d);
      if (!reset || !apu_enable) return 1'b0;
`ifdef GB_FS_EXT_DIV_EN
      return m_divprev && !div_bit;
`else
      return (m_cnt[d] % P[d]) == (P[d] - 1);
`endif
   endfunction

   function automatic logic [6:0] observed(input int d);
      if (d == 0)
         return {if4.frame_tick, if4.step, if4.clk_length_ctr, if4.clk_sweep, if4.clk_vol_env};
      return {if1.frame_tick, if1.step, if1.clk_length_ctr, if1.clk_sweep, if1.clk_vol_env};
   endfunction

   task automatic clear_counts();
      for (int d = 0; d < 2; d++) begin
         n_tick[d] = 0; n_len[d] = 0; n_sweep[d] = 0; n_env[d] = 0;
      end
   endtask

   task automatic clk_cycle();
      logic       ev;
      logic [6:0] o;
      for (int d = 0; d < 2; d++) begin
         ev = next_ev(d);
         if (!reset || !apu_enable) begin
            m_cnt[d]  = 0;
            m_step[d] = 0;
            m_out[d]  = '0;
         end else begin
            m_out[d] = {ev, 3'((m_step[d] + (ev ? 1 : 0)) % 8),
                        ev && (m_step[d] % 2 == 0),
                        ev && (m_step[d] % 4 == 2),
                        ev && (m_step[d] == 7)};
            m_step[d] = (m_step[d] + (ev ? 1 : 0)) % 8;
            m_cnt[d]  = m_cnt[d] + 1;
         end
      end
      m_divprev = reset ? div_bit : 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         o = observed(d);
         check(d == 0 ? "p4_outputs" : "p1_outputs", 32'(o), 32'(m_out[d]));
         n_tick[d]  += int'(o[6]);
         n_len[d]   += int'(o[2]);
         n_sweep[d] += int'(o[1]);
         n_env[d]   += int'(o[0]);
      end
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_step[d] = 0; m_out[d] = '0;
      end
      m_divprev = 1'b0;
      clear_counts();

      // Reset held with enable high.
      reset = 1'b0; apu_enable = 1'b1; div_bit = 1'b0;
      #1;
      clk_cycle();
      clk_cycle();
      check("reset_step", 32'(if4.step), 32'd0);
      check("reset_tick", 32'(if4.frame_tick), 32'd0);

      // Free run for 32 cycles.
      reset = 1'b1;
      clear_counts();
      for (int i = 0; i < 32; i++) clk_cycle();
`ifndef GB_FS_EXT_DIV_EN
      check("run_ticks_p4", 32'(n_tick[0]), 32'd8);
      check("run_len_p4", 32'(n_len[0]), 32'd4);
      check("run_sweep_p4", 32'(n_sweep[0]), 32'd2);
      check("run_env_p4", 32'(n_env[0]), 32'd1);
      check("run_ticks_p1", 32'(n_tick[1]), 32'd32);
      check("run_len_p1", 32'(n_len[1]), 32'd16);
      check("run_sweep_p1", 32'(n_sweep[1]), 32'd8);
      check("run_env_p1", 32'(n_env[1]), 32'd4);
`endif
      check("run_end_step", 32'(if4.step), 32'd0);

      // Disable when step 5 is pending.
      for (int i = 0; i < 80 && if4.step != 3'd5; i++) begin
         div_bit = ~div_bit;
         clk_cycle();
      end
      check("wait_step5", 32'(if4.step), 32'd5);
      apu_enable = 1'b0;
      clk_cycle();
      check("dis_step", 32'(if4.step), 32'd0);
      check("dis_strobes", 32'({if4.frame_tick, if4.clk_length_ctr, if4.clk_sweep, if4.clk_vol_env}), 32'd0);
      apu_enable = 1'b1;
      n = 0;
      for (int i = 0; i < 12 && !if4.frame_tick; i++) begin
         div_bit = ~div_bit;
         clk_cycle();
         n++;
      end
      check("reen_tick", 32'(if4.frame_tick), 32'd1);
      check("reen_strobe", 32'({if4.clk_length_ctr, if4.clk_sweep, if4.clk_vol_env}), 32'b100);
`ifndef GB_FS_EXT_DIV_EN
      check("reen_latency", 32'(n), 32'd4);
`endif

      // Reset on the cycle the frame event fires.
      for (int i = 0; i < 12 && !next_ev(0); i++) begin
         div_bit = ~div_bit;
         clk_cycle();
      end
      check("wait_ev", 32'(next_ev(0)), 32'd1);
      reset = 1'b0;
      clk_cycle();
      check("rst_ev_strobes", 32'({if4.frame_tick, if4.clk_length_ctr, if4.clk_sweep, if4.clk_vol_env}), 32'd0);
      check("rst_ev_step", 32'(if4.step), 32'd0);
      reset = 1'b1;

`ifdef GB_FS_EXT_DIV_EN
      // One DIV falling edge gives one frame.
      div_bit = 1'b1;
      clk_cycle();
      div_bit = 1'b0;
      clear_counts();
      for (int i = 0; i < 20; i++) clk_cycle();
      check("ext_one_tick", 32'(n_tick[0]), 32'd1);
      check("ext_one_len", 32'(n_len[0]), 32'd1);
      // Falling edge while disabled is ignored.
      apu_enable = 1'b0;
      div_bit = 1'b1;
      clk_cycle();
      div_bit = 1'b0;
      clear_counts();
      for (int i = 0; i < 4; i++) clk_cycle();
      apu_enable = 1'b1;
      for (int i = 0; i < 4; i++) clk_cycle();
      check("ext_dis_tick", 32'(n_tick[0]), 32'd0);
`endif

      // Randomised enable/reset/DIV traffic.
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 49) != 0);
         apu_enable = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 3) == 0) div_bit = ~div_bit;
         clk_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
